// File: rtl/dcache_tagv_nway_pkg.sv
// Shared types and tree-PLRU helpers for the n-way data-cache tag/valid array.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dcache_tagv_nway_pkg;

    // Widest supported tree: 8 ways -> 7 node bits, 3 way-index bits.
    localparam int MAX_WAY = 8;
    localparam int MAX_WB  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } flushState_t;

    // Way-index width for a power-of-two associativity.
    function automatic int wayBits(input int way);
        int b;
        b = 0;
        for (int i = 0; i < 4; i++) begin
            if ((1 << i) < way) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

    // Tree nodes are heap-numbered: node n has children 2n+1 (lower half)
    // and 2n+2 (upper half). A node bit of 1 steers the victim to the upper half.
    // Returns the new value of one node bit after touching 'way'; nodes off
    // the access path keep their current value.
    function automatic logic plruNodeNext(input int node, input logic cur,
                                          input logic [MAX_WB-1:0] way, input int wb);
        int   n;
        logic res;
        logic b;
        n   = 0;
        res = cur;
        for (int l = 0; l < MAX_WB; l++) begin
            if (l < wb) begin
                b = way[2'(wb - 1 - l)];
                if (n == node) begin
                    res = ~b;
                end
                n = 2 * n + (b ? 2 : 1);
            end
        end
        return res;
    endfunction

    // Follows the node bits from the root down to the pseudo-least-recent way.
    function automatic int plruSelect(input logic [MAX_WAY-2:0] state, input int wb);
        int n;
        int w;
        n = 0;
        w = 0;
        for (int l = 0; l < MAX_WB; l++) begin
            if (l < wb) begin
                if (state[3'(n)]) begin
                    w = 2 * w + 1;
                    n = 2 * n + 2;
                end else begin
                    w = 2 * w;
                    n = 2 * n + 1;
                end
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM: one write port, one synchronous read port.
// Latency: read data 1 cycle after raddr; read-during-write returns old data.
// Backpressure: none, accepts a read and a write every cycle. Contents are not reset.
module bram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/plru_tree.sv
// Tree-PLRU next state and victim choice for one set.
// Latency: combinational.
// Backpressure: none. Victim prefers the lowest invalid way, else the PLRU way.
module plru_tree
    import dcache_tagv_nway_pkg::*;
#(
    parameter int  WAY = 4,
    localparam int WB  = wayBits(WAY)
) (
    input  logic [WAY-2:0] plruState,
    input  logic [WAY-1:0] validVec,
    input  logic [WB-1:0]  accessWay,
    output logic [WAY-2:0] plruNext,
    output logic [WB-1:0]  victim
);

    logic [MAX_WAY-2:0] stateExt;
    logic [MAX_WB-1:0]  wayExt;

    always_comb begin
        stateExt            = '0;
        stateExt[WAY-2:0]   = plruState;
        wayExt              = '0;
        wayExt[WB-1:0]      = accessWay;
        plruNext            = plruState;
        for (int n = 0; n < WAY - 1; n++) begin
            plruNext[n] = plruNodeNext(n, plruState[n], wayExt, WB);
        end
        victim = WB'(plruSelect(stateExt, WB));
        // Descending scan so the lowest invalid way is the one left standing.
        for (int w = WAY - 1; w >= 0; w--) begin
            if (!validVec[w]) begin
                victim = WB'(w);
            end
        end
    end

endmodule

// File: rtl/dcache_tagv_nway.sv
// N-way data-cache tag/valid array with tree-PLRU replacement and flush sweep.
// Latency: lookup response one cycle after rd_valid; fill/invalidate take effect at the next edge.
// Backpressure: none; busy high for 2^ADDR_WIDTH cycles during a flush, when all requests are dropped.
//
// Ports: clk/rst (async active-high); rd_valid/rd_addr/rd_tag lookup request;
// rsp_valid/hit/hit_way/miss/victim_way lookup response; wr_en/inv_en with
// wr_addr/wr_way/wr_tag fill or invalidate; flush_req/busy invalidate-all.
// Option: define DCACHE_TAGV_BYPASS_EN to forward a same-cycle fill/invalidate
// of the looked-up set into that lookup's response.
module dcache_tagv_nway
    import dcache_tagv_nway_pkg::*;
#(
    parameter int  ADDR_WIDTH = 6,
    parameter int  TAG_WIDTH  = 20,
    parameter int  WAY        = 4,
    localparam int WB         = wayBits(WAY)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [TAG_WIDTH-1:0]  rd_tag,
    output logic                  rsp_valid,
    output logic [WAY-1:0]        hit,
    output logic [WB-1:0]         hit_way,
    output logic                  miss,
    output logic [WB-1:0]         victim_way,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WB-1:0]         wr_way,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic                  inv_en,
    input  logic                  flush_req,
    output logic                  busy
);

    localparam int NSETS = 1 << ADDR_WIDTH;

    flushState_t           state;
    flushState_t           stateNext;
    logic [ADDR_WIDTH-1:0] sweepCnt;

    logic [WAY-1:0]        validQ [NSETS];
    logic [WAY-2:0]        plruQ  [NSETS];

    logic                  idle;
    logic                  rdAcc;
    logic                  wrAcc;
    logic                  invAcc;

    logic                  rspValidQ;
    logic [ADDR_WIDTH-1:0] rspSet;
    logic [TAG_WIDTH-1:0]  rspTag;
    logic [WAY-1:0]        rspValidVec;
    logic [WAY-1:0]        validLook;

    logic [TAG_WIDTH-1:0]  tagRd  [WAY];
    logic [TAG_WIDTH-1:0]  tagCmp [WAY];
    logic [WAY-1:0]        hitVec;
    logic [WB-1:0]         hitEnc;
    logic                  hitUpd;

    logic [WAY-2:0]        plruHitNext;
    logic [WAY-2:0]        plruWrNext;
    logic [WB-1:0]         victimRaw;
    logic [MAX_WB-1:0]     wrWayExt;

    assign idle   = (state == IDLE);
    // A lookup arriving with flush_req would respond inside the sweep, so it is dropped.
    assign rdAcc  = rd_valid && idle && !flush_req;
    // Invalidate beats a simultaneous fill: the fill is suppressed entirely.
    assign invAcc = inv_en && idle;
    assign wrAcc  = wr_en && !inv_en && idle;

    // ---------------- flush FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sweepCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == SWEEP) begin
                sweepCnt <= sweepCnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (flush_req) stateNext = SWEEP;
            SWEEP:   if (sweepCnt == '1) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state == SWEEP);

    // ---------------- tag storage ----------------
    for (genvar w = 0; w < WAY; w++) begin : gWay
        bram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (TAG_WIDTH)
        ) uTag (
            .clk   (clk),
            .we    (wrAcc && (wr_way == WB'(w))),
            .waddr (wr_addr),
            .wdata (wr_tag),
            .raddr (rd_addr),
            .rdata (tagRd[w])
        );
    end

`ifdef DCACHE_TAGV_BYPASS_EN
    // The bram returns pre-write data on a same-address write, so the new
    // tag is captured alongside the lookup and muxed in on the response.
    logic [WAY-1:0]       fwdSel;
    logic [TAG_WIDTH-1:0] fwdTag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwdSel <= '0;
            fwdTag <= '0;
        end else if (rdAcc) begin
            for (int w = 0; w < WAY; w++) begin
                fwdSel[w] <= wrAcc && (wr_addr == rd_addr) && (wr_way == WB'(w));
            end
            fwdTag <= wr_tag;
        end
    end

    always_comb begin
        for (int w = 0; w < WAY; w++) begin
            tagCmp[w] = fwdSel[w] ? fwdTag : tagRd[w];
        end
    end

    always_comb begin
        validLook = validQ[rd_addr];
        if (wr_addr == rd_addr) begin
            if (invAcc) begin
                validLook[wr_way] = 1'b0;
            end else if (wrAcc) begin
                validLook[wr_way] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        for (int w = 0; w < WAY; w++) begin
            tagCmp[w] = tagRd[w];
        end
    end

    always_comb begin
        validLook = validQ[rd_addr];
    end
`endif

    // ---------------- lookup response ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspValidQ   <= 1'b0;
            rspSet      <= '0;
            rspTag      <= '0;
            rspValidVec <= '0;
        end else begin
            rspValidQ <= rdAcc;
            if (rdAcc) begin
                rspSet      <= rd_addr;
                rspTag      <= rd_tag;
                rspValidVec <= validLook;
            end
        end
    end

    always_comb begin
        hitVec = '0;
        hitEnc = '0;
        for (int w = WAY - 1; w >= 0; w--) begin
            if (rspValidQ && rspValidVec[w] && (tagCmp[w] == rspTag)) begin
                hitVec[w] = 1'b1;
                hitEnc    = WB'(w);
            end
        end
    end

    assign hitUpd    = rspValidQ && (|hitVec);
    assign rsp_valid = rspValidQ;
    assign hit       = hitVec;
    assign hit_way   = hitEnc;
    assign miss      = rspValidQ && !(|hitVec);

    // Victim uses the set's current valid/PLRU state so it matches what a
    // fill issued right after the response would observe.
    plru_tree #(
        .WAY (WAY)
    ) uPlru (
        .plruState (plruQ[rspSet]),
        .validVec  (validQ[rspSet]),
        .accessWay (hitEnc),
        .plruNext  (plruHitNext),
        .victim    (victimRaw)
    );

    assign victim_way = rspValidQ ? victimRaw : '0;

    always_comb begin
        wrWayExt         = '0;
        wrWayExt[WB-1:0] = wr_way;
        plruWrNext       = plruQ[wr_addr];
        for (int n = 0; n < WAY - 1; n++) begin
            plruWrNext[n] = plruNodeNext(n, plruQ[wr_addr][n], wrWayExt, WB);
        end
    end

    // ---------------- valid bits and PLRU state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSETS; s++) begin
                validQ[s] <= '0;
                plruQ[s]  <= '0;
            end
        end else if (state == SWEEP) begin
            validQ[sweepCnt] <= '0;
            plruQ[sweepCnt]  <= '0;
        end else begin
            if (invAcc) begin
                validQ[wr_addr][wr_way] <= 1'b0;
            end else if (wrAcc) begin
                validQ[wr_addr][wr_way] <= 1'b1;
            end
            if (hitUpd) begin
                plruQ[rspSet] <= plruHitNext;
            end
            // Issued after the hit update so a fill to the same set wins.
            if (wrAcc) begin
                plruQ[wr_addr] <= plruWrNext;
            end
        end
    end

endmodule

// File: tb/tb_dcache_tagv_nway.sv
module tb_dcache_tagv_nway;

    localparam int AW    = 6;
    localparam int TW    = 20;
    localparam int WAYS  = 4;
    localparam int NSETS = 1 << AW;

    logic          clk;
    logic          rst;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic [TW-1:0] rd_tag;
    logic          rsp_valid;
    logic [3:0]    hit;
    logic [1:0]    hit_way;
    logic          miss;
    logic [1:0]    victim_way;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_way;
    logic [TW-1:0] wr_tag;
    logic          inv_en;
    logic          flush_req;
    logic          busy;

    dcache_tagv_nway #(
        .ADDR_WIDTH (AW),
        .TAG_WIDTH  (TW),
        .WAY        (WAYS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_tag     (rd_tag),
        .rsp_valid  (rsp_valid),
        .hit        (hit),
        .hit_way    (hit_way),
        .miss       (miss),
        .victim_way (victim_way),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_way     (wr_way),
        .wr_tag     (wr_tag),
        .inv_en     (inv_en),
        .flush_req  (flush_req),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0] hit;
        logic [1:0] hw;
        logic       miss;
        logic [1:0] vic;
    } exp_t;

    exp_t sb[$];

    int vecCnt = 0;
    int errCnt = 0;

    // Reference model state
    logic [TW-1:0] mTag  [NSETS][WAYS];
    bit            mVal  [NSETS][WAYS];
    bit            mPlru [NSETS][WAYS-1];
    bit            mSweep;
    int            mCnt;
    bit            pendHit;
    int            pendSet;
    int            pendWay;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        for (int s = 0; s < NSETS; s++) begin
            for (int w = 0; w < WAYS; w++) mVal[s][w] = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) mPlru[s][n] = 1'b0;
        end
        mSweep  = 1'b0;
        mCnt    = 0;
        pendHit = 1'b0;
    endfunction

    // Interval-halving walk: bit=1 means the older half is the upper half.
    function automatic int mSel(input int s);
        int lo, hi, n, mid;
        lo = 0; hi = WAYS; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mPlru[s][n]) begin lo = mid; n = 2 * n + 2; end
            else             begin hi = mid; n = 2 * n + 1; end
        end
        return lo;
    endfunction

    function automatic void mTouch(input int s, input int w);
        int lo, hi, n, mid;
        lo = 0; hi = WAYS; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w >= mid) begin mPlru[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
            else          begin mPlru[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
        end
    endfunction

    function automatic int mVictim(input int s);
        for (int w = 0; w < WAYS; w++) if (!mVal[s][w]) return w;
        return mSel(s);
    endfunction

    // One clock: drive at negedge, update model, check at the next negedge.
    task automatic step(input bit rv, input int ra, input logic [TW-1:0] rt,
                        input bit we, input bit ie, input int wa, input int ww,
                        input logic [TW-1:0] wt, input bit fl);
        exp_t          e;
        bit            rdAcc, wrAcc, invAcc, idle;
        logic [TW-1:0] lkTag [WAYS];
        bit            lkVal [WAYS];

        rd_valid  = rv;
        rd_addr   = AW'(ra);
        rd_tag    = rt;
        wr_en     = we;
        inv_en    = ie;
        wr_addr   = AW'(wa);
        wr_way    = 2'(ww);
        wr_tag    = wt;
        flush_req = fl;

        idle   = !mSweep;
        rdAcc  = rv && idle && !fl;
        invAcc = ie && idle;
        wrAcc  = we && !ie && idle;
        for (int i = 0; i < WAYS; i++) begin
            lkTag[i] = mTag[ra][i];
            lkVal[i] = mVal[ra][i];
        end

        if (mSweep) begin
            for (int i = 0; i < WAYS; i++) mVal[mCnt][i] = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) mPlru[mCnt][n] = 1'b0;
            if (mCnt == NSETS - 1) begin mSweep = 1'b0; mCnt = 0; end
            else mCnt++;
        end else begin
            if (pendHit && !(wrAcc && wa == pendSet)) mTouch(pendSet, pendWay);
            if (invAcc) mVal[wa][ww] = 1'b0;
            else if (wrAcc) begin
                mVal[wa][ww] = 1'b1;
                mTag[wa][ww] = wt;
                mTouch(wa, ww);
            end
            if (fl) begin mSweep = 1'b1; mCnt = 0; end
        end

        pendHit = 1'b0;
        if (rdAcc) begin
`ifdef DCACHE_TAGV_BYPASS_EN
            for (int i = 0; i < WAYS; i++) begin
                lkTag[i] = mTag[ra][i];
                lkVal[i] = mVal[ra][i];
            end
`endif
            e = '0;
            for (int i = WAYS - 1; i >= 0; i--) begin
                if (lkVal[i] && lkTag[i] == rt) begin
                    e.hit[i] = 1'b1;
                    e.hw     = 2'(i);
                end
            end
            e.miss = (e.hit == 4'b0);
            e.vic  = 2'(mVictim(ra));
            sb.push_back(e);
            if (!e.miss) begin
                pendHit = 1'b1;
                pendSet = ra;
                pendWay = int'(e.hw);
            end
        end

        @(posedge clk);
        @(negedge clk);

        checkVal("rsp_valid", 32'(rsp_valid), 32'(rdAcc));
        checkVal("busy", 32'(busy), 32'(mSweep));
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkVal("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                checkVal("hit", 32'(hit), 32'(e.hit));
                checkVal("hit_way", 32'(hit_way), 32'(e.hw));
                checkVal("miss", 32'(miss), 32'(e.miss));
                checkVal("victim_way", 32'(victim_way), 32'(e.vic));
            end
        end
    endtask

    task automatic doRd(input int s, input logic [TW-1:0] t);
        step(1'b1, s, t, 1'b0, 1'b0, 0, 0, '0, 1'b0);
    endtask

    task automatic doWr(input int s, input int w, input logic [TW-1:0] t);
        step(1'b0, 0, '0, 1'b1, 1'b0, s, w, t, 1'b0);
    endtask

    task automatic doIdle();
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 0, '0, 1'b0);
    endtask

    int busyCnt;

    initial begin
        rst = 1'b1;
        rd_valid = 1'b0; rd_addr = '0; rd_tag = '0;
        wr_en = 1'b0; wr_addr = '0; wr_way = '0; wr_tag = '0;
        inv_en = 1'b0; flush_req = 1'b0;
        modelReset();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < WAYS; w++) mTag[s][w] = '0;

        repeat (2) @(negedge clk);
        checkVal("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkVal("rst_hit", 32'(hit), 32'd0);
        checkVal("rst_hit_way", 32'(hit_way), 32'd0);
        checkVal("rst_miss", 32'(miss), 32'd0);
        checkVal("rst_victim", 32'(victim_way), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Cold lookup
        doRd(5, 20'h123);
        checkVal("cold_miss", 32'(miss), 32'd1);
        checkVal("cold_victim", 32'(victim_way), 32'd0);

        // Fill set 5, then hit and a follow-up miss
        doWr(5, 0, 20'hA);
        doWr(5, 1, 20'hB);
        doWr(5, 2, 20'hC);
        doWr(5, 3, 20'hD);
        doRd(5, 20'hC);
        checkVal("fill_hit_vec", 32'(hit), 32'h4);
        checkVal("fill_hit_way", 32'(hit_way), 32'd2);
        doRd(5, 20'hF);
        checkVal("post_hit_miss", 32'(miss), 32'd1);
        checkVal("victim_not_2", 32'(victim_way != 2'd2), 32'd1);

        // Invalidate wins over a simultaneous fill
        step(1'b0, 0, '0, 1'b1, 1'b1, 5, 1, 20'h99, 1'b0);
        doRd(5, 20'hB);
        checkVal("inv_miss", 32'(miss), 32'd1);
        checkVal("inv_victim", 32'(victim_way), 32'd1);

        // Same-cycle fill and lookup of set 3
        step(1'b1, 3, 20'h55, 1'b1, 1'b0, 3, 2, 20'h55, 1'b0);
`ifdef DCACHE_TAGV_BYPASS_EN
        checkVal("raw_hit_way", 32'(hit_way), 32'd2);
        checkVal("raw_miss", 32'(miss), 32'd0);
`else
        checkVal("raw_miss", 32'(miss), 32'd1);
`endif

        // Random traffic on a few sets so fills, hits and same-set collisions mix
        for (int k = 0; k < 200; k++) begin
            int ra, wa;
            ra = int'($urandom_range(0, 3));
            wa = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, ra, 20'($urandom_range(0, 5)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 wa, int'($urandom_range(0, 3)), 20'($urandom_range(0, 5)), 1'b0);
        end

        // Flush: busy exactly NSETS cycles, lookups ignored, re-request ignored
        busyCnt = 0;
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 0, '0, 1'b1);
        busyCnt += int'(busy);
        for (int k = 0; k < 70; k++) begin
            step(1'b1, int'($urandom_range(0, 7)), 20'($urandom_range(0, 5)),
                 1'b0, 1'b0, 0, 0, '0, k == 20);
            busyCnt += int'(busy);
        end
        checkVal("flush_len", 32'(busyCnt), 32'(NSETS));

        for (int s = 0; s < 8; s++)
            for (int t = 0; t < 6; t++) doRd(s, 20'(t));
        doRd(5, 20'hA);
        checkVal("post_flush_miss", 32'(miss), 32'd1);

        // Reset in the middle of a sweep
        doWr(2, 1, 20'h77);
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 0, '0, 1'b1);
        for (int k = 0; k < 10; k++) doIdle();
        #2;
        rst = 1'b1;
        #1;
        checkVal("midsweep_busy", 32'(busy), 32'd0);
        checkVal("midsweep_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        sb.delete();
        doWr(3, 0, 20'h7);
        doRd(3, 20'h7);
        checkVal("after_rst_hit", 32'(hit), 32'h1);
        doRd(2, 20'h77);
        checkVal("after_rst_miss", 32'(miss), 32'd1);
        doIdle();
        checkVal("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/dcache_tagv_nway.md
DCACHE_TAGV_NWAY -- requirements
Module: dcache_tagv_nway

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, set-index width (2^ADDR_WIDTH sets).
REQ-002 SHALL have parameter TAG_WIDTH, default 20, stored tag width.
REQ-003 SHALL have parameter WAY, default 4, associativity; power of two, 2..8; WB = log2(WAY).
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have rd_valid  in  1  lookup request.
REQ-006 SHALL have rd_addr  in  ADDR_WIDTH  lookup set.
REQ-007 SHALL have rd_tag  in  TAG_WIDTH  tag to compare; sampled with rd_valid.
REQ-008 SHALL have rsp_valid  out  1  lookup result valid.
REQ-009 SHALL have hit  out  WAY  one-hot hit vector.
REQ-010 SHALL have hit_way  out  WB  encoded hit way; miss  out  1  rsp_valid and no hit.
REQ-011 SHALL have victim_way  out  WB  replacement way for the responded set.
REQ-012 SHALL have wr_en  in  1  tag fill; wr_addr  in  ADDR_WIDTH; wr_way  in  WB; wr_tag  in  TAG_WIDTH.
REQ-013 SHALL have inv_en  in  1  invalidate way wr_way of set wr_addr.
REQ-014 SHALL have flush_req  in  1  invalidate-all pulse; busy  out  1  flush in progress.

Function
REQ-015 SHALL return lookups with latency 1: rd_valid at cycle t gives rsp_valid, hit, hit_way, miss, victim_way at t+1 for the set and tag sampled at t.
REQ-016 hit[i] SHALL be 1 only if way i's stored tag equals the sampled rd_tag and way i's valid bit is 1. hit_way SHALL be the lowest hit index; it SHALL be 0 on a miss.
REQ-017 Valid bits SHALL be held in flops, WAY x 2^ADDR_WIDTH. Tags SHALL be held in one bram per way: synchronous read, one write port.
REQ-018 wr_en SHALL write wr_tag into way wr_way and set its valid bit at the next edge. inv_en SHALL clear the valid bit only. If both are asserted, inv_en SHALL win.
REQ-019 Each set SHALL keep a WAY-1 bit tree-PLRU state.
REQ-020 On a hit response, the set's PLRU SHALL point away from hit_way. On wr_en, the set's PLRU SHALL point away from wr_way. If both target the same set in the same cycle, the wr_en update SHALL apply.
REQ-021 victim_way SHALL be the lowest-index invalid way of the set if one exists; otherwise it SHALL be the PLRU-selected way.
REQ-022 FSM SHALL have states IDLE and SWEEP. IDLE SHALL go to SWEEP on flush_req. SWEEP SHALL clear all valid bits and the PLRU state of one set per cycle, counting sets 0..2^ADDR_WIDTH-1, then return to IDLE.
REQ-023 busy SHALL be high exactly during SWEEP; a flush SHALL take 2^ADDR_WIDTH cycles.
REQ-024 While busy: rd_valid, wr_en and inv_en SHALL be ignored, rsp_valid SHALL be 0, and flush_req SHALL be ignored. The sweep counter SHALL wrap to 0 on completion.

Reset
REQ-025 rst SHALL asynchronously clear all valid bits, all PLRU state, the sweep counter, rsp_valid, hit, hit_way, miss, victim_way and busy, and SHALL force the FSM to IDLE.
REQ-026 rst during SWEEP SHALL abort the sweep, and the block SHALL be usable on the first edge after rst deasserts. Bram tag contents are not reset.

Configuration
REQ-027 Macro DCACHE_TAGV_BYPASS_EN SHALL enable read-after-write forwarding.
REQ-028 With the macro defined: a wr_en or inv_en in the same cycle as rd_valid to the same set SHALL be reflected in that lookup's response.
REQ-029 Without the macro: that lookup SHALL see the pre-write tag and valid state, and no forwarding logic SHALL be instantiated.

Structure
REQ-030 A shared package SHALL hold the PLRU update/select functions, the FSM state typedef and the WB computation.
REQ-031 The existing bram module SHALL be reused per way. One new sub-module, plru_tree, SHALL be natural: combinational next-state and victim logic for one set.

Verification
REQ-032 After rst, rd set 5 tag 0x123 -> rsp_valid=1, miss=1, victim_way=0.
REQ-033 Fill ways 0..3 of set 5 with tags 0xA..0xD, then rd tag 0xC -> hit=4'b0100, hit_way=2; the following rd with tag 0xF -> miss=1 and victim_way not equal to 2.
REQ-034 inv_en with wr_en on set 5 way 1 -> way 1 invalid, and the next lookup of its tag -> miss=1, victim_way=1.
REQ-035 flush_req -> busy high for 64 cycles (defaults) with rd_valid ignored; afterwards, every earlier filled tag -> miss; flush_req during busy -> no extension.
REQ-036 Same-cycle wr set 3 way 2 tag 0x55 and rd set 3 tag 0x55 -> hit_way=2 with DCACHE_TAGV_BYPASS_EN, miss=1 without; rst asserted mid-sweep -> busy=0 immediately.
